// File: rtl/if_pc_gen_pkg.sv
// Shared constants for the instruction-fetch PC generator: boot vector,
// IF exception flag index and FSM state encodings.
package if_pc_gen_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam int          EXC_IF_ADEL      = 0;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_BR_PEND = 2'd2
    } pc_state_t;

endpackage

// File: rtl/if_addr_map.sv
// Virtual-to-physical fetch address map: kseg0/kseg1 fold onto the low
// 512 MB, every other segment passes through unmapped.
module if_addr_map (
    input  logic [31:0] vaddr,
    output logic [31:0] paddr
);

    always_comb begin
        if (vaddr[31:30] == 2'b10) begin
            paddr = {3'b000, vaddr[28:0]};
        end else begin
            paddr = vaddr;
        end
    end

endmodule

// File: rtl/if_pc_gen.sv
// IF-stage PC generator: boot sequencing, sequential fetch, branch and
// exception redirects, with a one-deep pending branch held across stalls.
module if_pc_gen
    import if_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [3:0]  stall_i,
    input  logic        branch_enable_i,
    input  logic [31:0] branch_target_i,
    input  logic        exception_i,
    input  logic [31:0] exception_pc_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_exception_type_o,
    output logic        if_inst_ren_o,
    output logic [31:0] inst_addr_o
);

    pc_state_t   state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] pend_target, pend_target_next;
    logic        advance;

    assign advance = (stall_i == 4'b0000);

    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        pend_target_next = pend_target;

        if (exception_i) begin
            pc_next          = exception_pc_i;
            pend_target_next = '0;
            state_next       = ST_RUN;
        end else begin
            unique case (state)
                ST_BOOT: begin
                    state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (advance) begin
                        pc_next = branch_enable_i ? branch_target_i : pc + 32'd4;
                    end else if (branch_enable_i) begin
                        pend_target_next = branch_target_i;
                        state_next       = ST_BR_PEND;
                    end
                end
                ST_BR_PEND: begin
                    if (advance) begin
                        // A branch resolved in the release cycle is younger than the pending one.
                        pc_next          = branch_enable_i ? branch_target_i : pend_target;
                        pend_target_next = '0;
                        state_next       = ST_RUN;
                    end else if (branch_enable_i) begin
                        pend_target_next = branch_target_i;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            pend_target <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            pend_target <= pend_target_next;
        end
    end

    always_comb begin
        if_exception_type_o              = '0;
        if_exception_type_o[EXC_IF_ADEL] = (pc[1:0] != 2'b00);
    end

    assign if_pc_o       = pc;
    assign if_inst_ren_o = (state != ST_BOOT) && (pc[1:0] == 2'b00);

    if_addr_map u_addr_map (
        .vaddr (pc),
        .paddr (inst_addr_o)
    );

endmodule

// File: tb/tb_if_pc_gen.sv
// Scoreboarded bench for if_pc_gen: directed redirect/stall/reset scenarios
// with expected fetch state queued at drive time and checked after each edge.
module tb_if_pc_gen;

    logic        clock_i;
    logic        reset_i;
    logic [3:0]  stall_i;
    logic        branch_enable_i;
    logic [31:0] branch_target_i;
    logic        exception_i;
    logic [31:0] exception_pc_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_exception_type_o;
    logic        if_inst_ren_o;
    logic [31:0] inst_addr_o;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] pc;
        logic        boot;
        string       tag;
    } exp_t;

    exp_t sb[$];

    if_pc_gen dut (
        .clock_i             (clock_i),
        .reset_i             (reset_i),
        .stall_i             (stall_i),
        .branch_enable_i     (branch_enable_i),
        .branch_target_i     (branch_target_i),
        .exception_i         (exception_i),
        .exception_pc_i      (exception_pc_i),
        .if_pc_o             (if_pc_o),
        .if_exception_type_o (if_exception_type_o),
        .if_inst_ren_o       (if_inst_ren_o),
        .inst_addr_o         (inst_addr_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    // Every output is derived from the expected PC and whether the FSM is still booting.
    task automatic check_outputs(input exp_t e);
        logic [31:0] want_addr;
        logic [31:0] want_exc;
        logic        want_ren;
        want_addr = (e.pc[31:30] == 2'b10) ? {3'b000, e.pc[28:0]} : e.pc;
        want_exc  = {31'b0, (e.pc[1:0] != 2'b00)};
        want_ren  = !e.boot && (e.pc[1:0] == 2'b00);
        check({e.tag, ".pc"},   if_pc_o, e.pc);
        check({e.tag, ".ren"},  {31'b0, if_inst_ren_o}, {31'b0, want_ren});
        check({e.tag, ".exc"},  if_exception_type_o, want_exc);
        check({e.tag, ".addr"}, inst_addr_o, want_addr);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            check_outputs(e);
        end
    endtask

    task automatic expect_now(input string tag, input logic [31:0] pc, input logic boot);
        sb.push_back('{pc: pc, boot: boot, tag: tag});
        pop_check();
    endtask

    task automatic step(input string tag, input logic [3:0] stall, input logic br,
                        input logic [31:0] tgt, input logic exc, input logic [31:0] epc,
                        input logic [31:0] want_pc);
        stall_i         = stall;
        branch_enable_i = br;
        branch_target_i = tgt;
        exception_i     = exc;
        exception_pc_i  = epc;
        sb.push_back('{pc: want_pc, boot: 1'b0, tag: tag});
        @(posedge clock_i);
        #1;
        pop_check();
    endtask

    initial begin
        reset_i         = 1'b1;
        stall_i         = 4'b0000;
        branch_enable_i = 1'b0;
        branch_target_i = '0;
        exception_i     = 1'b0;
        exception_pc_i  = '0;

        #2;
        expect_now("rst", 32'hBFC0_0000, 1'b1);
        check("rst.addr_abs", inst_addr_o, 32'h1FC0_0000);
        @(posedge clock_i);
        #1;
        expect_now("rst_hold", 32'hBFC0_0000, 1'b1);

        // Boot: one cycle with fetch disabled, then sequential fetch.
        reset_i = 1'b0;
        #1;
        expect_now("boot.c0", 32'hBFC0_0000, 1'b1);
        step("boot.c1", 4'b0000, 1'b0, '0, 1'b0, '0, 32'hBFC0_0000);
        step("boot.c2", 4'b0000, 1'b0, '0, 1'b0, '0, 32'hBFC0_0004);

        // Branch resolved under a 3-cycle stall.
        step("bstall.0", 4'b0010, 1'b1, 32'h8000_1000, 1'b0, '0, 32'hBFC0_0004);
        step("bstall.1", 4'b0010, 1'b0, '0, 1'b0, '0, 32'hBFC0_0004);
        step("bstall.2", 4'b0010, 1'b0, '0, 1'b0, '0, 32'hBFC0_0004);
        step("bstall.go", 4'b0000, 1'b0, '0, 1'b0, '0, 32'h8000_1000);
        step("bstall.seq", 4'b0000, 1'b0, '0, 1'b0, '0, 32'h8000_1004);

        // Pending target overwritten while stalled; release-cycle branch wins.
        step("ovr.0", 4'b0001, 1'b1, 32'h8000_2000, 1'b0, '0, 32'h8000_1004);
        step("ovr.1", 4'b1000, 1'b1, 32'h8000_3000, 1'b0, '0, 32'h8000_1004);
        step("ovr.go", 4'b0000, 1'b0, '0, 1'b0, '0, 32'h8000_3000);
        step("win.0", 4'b0100, 1'b1, 32'h8000_4000, 1'b0, '0, 32'h8000_3000);
        step("win.go", 4'b0000, 1'b1, 32'h8000_5000, 1'b0, '0, 32'h8000_5000);
        step("run.br", 4'b0000, 1'b1, 32'h0000_0100, 1'b0, '0, 32'h0000_0100);

        // Exception while pending and stalled discards the pending target.
        step("exc.pend", 4'b0010, 1'b1, 32'h8000_6000, 1'b0, '0, 32'h0000_0100);
        step("exc.hit", 4'b0010, 1'b0, '0, 1'b1, 32'hBFC0_0380, 32'hBFC0_0380);
        step("exc.hold", 4'b0010, 1'b0, '0, 1'b0, '0, 32'hBFC0_0380);
        step("exc.go", 4'b0000, 1'b0, '0, 1'b0, '0, 32'hBFC0_0384);

        // Misaligned branch target raises AdEL and suppresses the fetch.
        step("adel.br", 4'b0000, 1'b1, 32'h8000_0002, 1'b0, '0, 32'h8000_0002);
        step("adel.seq", 4'b0000, 1'b0, '0, 1'b0, '0, 32'h8000_0006);

        // Top-of-memory wrap through an unmapped segment.
        step("wrap.ld", 4'b0000, 1'b0, '0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        step("wrap.go", 4'b0000, 1'b0, '0, 1'b0, '0, 32'h0000_0000);

        // Asynchronous reset mid-cycle during BR_PEND drops the pending target.
        step("arst.pend", 4'b0001, 1'b1, 32'h8000_7000, 1'b0, '0, 32'h0000_0000);
        #2;
        reset_i = 1'b1;
        #1;
        expect_now("arst.now", 32'hBFC0_0000, 1'b1);
        @(posedge clock_i);
        #1;
        reset_i         = 1'b0;
        stall_i         = 4'b0000;
        branch_enable_i = 1'b0;
        #1;
        expect_now("arst.c0", 32'hBFC0_0000, 1'b1);
        step("arst.c1", 4'b0000, 1'b0, '0, 1'b0, '0, 32'hBFC0_0000);
        step("arst.c2", 4'b0000, 1'b0, '0, 1'b0, '0, 32'hBFC0_0004);
        step("arst.c3", 4'b0000, 1'b0, '0, 1'b0, '0, 32'hBFC0_0008);

        if (sb.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/if_pc_gen.md
IF_PC_GEN -- requirements
Module: if_pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC00000, boot fetch address.
REQ-002 SHALL have port clock_i, input, 1, sole clock; all state updates on posedge.
REQ-003 SHALL have port reset_i, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port stall_i, input, 4, pipeline stall vector; the IF stage advances only when it equals 4'b0000.
REQ-005 SHALL have port branch_enable_i, input, 1, branch/jump taken, resolved in ID.
REQ-006 SHALL have port branch_target_i, input, 32, branch/jump target, valid when branch_enable_i=1.
REQ-007 SHALL have port exception_i, input, 1, pipeline flush from the exception unit.
REQ-008 SHALL have port exception_pc_i, input, 32, handler address or EPC, valid when exception_i=1.
REQ-009 SHALL have port if_pc_o, output, 32, current fetch PC, drives the IF/post-IF register.
REQ-010 SHALL have port if_exception_type_o, output, 32, IF-stage exception flags.
REQ-011 SHALL have port if_inst_ren_o, output, 1, instruction-memory read enable.
REQ-012 SHALL have port inst_addr_o, output, 32, physical fetch address.

Function
REQ-013 SHALL hold a 32-bit PC register; if_pc_o is its value.
REQ-014 SHALL implement FSM states BOOT, RUN, BR_PEND.
REQ-015 SHALL enter BOOT on reset, then go BOOT->RUN on the first clock edge after reset deasserts, with PC remaining RESET_PC.
REQ-016 SHALL, in any state, on exception_i=1: load PC<=exception_pc_i, go to RUN, and discard any pending target, regardless of stall_i.
REQ-017 SHALL, in RUN with stall_i==0 and branch_enable_i=1, load PC<=branch_target_i.
REQ-018 SHALL, in RUN with stall_i==0 and no branch, load PC<=PC+4 modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-019 SHALL, in RUN with stall_i!=0: hold PC; if branch_enable_i=1, capture branch_target_i into pend_target and go to BR_PEND.
REQ-020 SHALL, in BR_PEND with stall_i!=0: hold PC; a new branch_enable_i=1 overwrites pend_target.
REQ-021 SHALL, in BR_PEND with stall_i==0: load PC<=pend_target (or branch_target_i if branch_enable_i=1 that same cycle, which wins) and go to RUN.
REQ-022 SHALL drive if_inst_ren_o = (state!=BOOT) && (PC[1:0]==2'b00), combinationally.
REQ-023 SHALL drive if_exception_type_o with bit `EXC_IF_ADEL set iff PC[1:0]!=0 and all other bits 0.
REQ-024 SHALL derive inst_addr_o from PC as follows: PC[31:30]==2'b10 (kseg0/kseg1) -> {3'b000,PC[28:0]}; otherwise PC unchanged.
REQ-025 SHALL give a latency of one cycle from a redirect input to the new if_pc_o.

Reset
REQ-026 SHALL, while reset_i=1, force PC=RESET_PC, state=BOOT, pend_target=0, if_inst_ren_o=0, if_exception_type_o=0, and inst_addr_o=32'h1FC00000.
REQ-027 SHALL, on reset asserted mid-BR_PEND, drop the pending target with no redirect after release.

Structure
REQ-028 SHALL take RESET_PC default, `EXC_IF_ADEL bit index (0), and the state encodings from the shared defines.vh.
REQ-029 SHALL place the address translation in sub-module if_addr_map (combinational).
REQ-030 SHALL keep the PC register, pend_target, and FSM in if_pc_gen.

Verification
REQ-031 Reset release with stall_i=0 -> cycle0 pc=BFC00000 ren=0; cycle1 ren=1, pc=BFC00000; cycle2 pc=BFC00004.
REQ-032 Branch target 0x80001000 while stall_i=4'b0010 for 3 cycles -> pc holds, then 0x80001000 one cycle after stall clears, with inst_addr_o=0x00001000.
REQ-033 exception_i=1 with exception_pc_i=0xBFC00380 while in BR_PEND and stalled -> next pc=0xBFC00380; pending target never appears.
REQ-034 Branch to 0x80000002 -> if_inst_ren_o=0, if_exception_type_o=32'h00000001; next advance to 0x80000006.
REQ-035 PC=0xFFFFFFFC with no stall -> next pc=0x00000000 and inst_addr_o=0x00000000.
REQ-036 Reset asserted asynchronously mid-cycle during BR_PEND -> outputs immediately take reset values; the pending target is lost.
